button_event_decoder: RTL and testbench

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/button_event_decoder.sv | 138 +++++++++++++
 tb/tb_button_event_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// ============================================================================
// Module   : button_event_decoder
// Purpose  : Turns a debounced button level into press/release, short,
//            double-click, long-press and auto-repeat event pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_event_decoder #(
    parameter logic [23:0] LONG_CYCLES   = 24'd12_000_000,
    parameter logic [23:0] GAP_CYCLES    = 24'd3_000_000,
    parameter logic [23:0] REPEAT_CYCLES = 24'd2_400_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESSED  = 3'd1,
        LONG     = 3'd2,
        WAIT_GAP = 3'd3,
        SECOND   = 3'd4
    } state_t;

    state_t      r_state;
    logic [23:0] r_timer;
    logic        r_btn_q;
    logic        w_rise;
    logic        w_fall;
    logic [23:0] w_timer_inc;

    assign w_rise      = btn & ~r_btn_q;
    assign w_fall      = ~btn & r_btn_q;
    // Saturating increment: the shared timer must never wrap.
    assign w_timer_inc = (r_timer == 24'hFF_FFFF) ? r_timer : r_timer + 24'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_timer       <= 24'd0;
            r_btn_q       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            r_btn_q       <= btn;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_timer <= 24'd0;
                    if (w_rise) begin
                        r_state     <= PRESSED;
                        press_pulse <= 1'b1;
                    end
                end
                PRESSED: begin
                    // A release coinciding with the long threshold stays short.
                    if (w_fall) begin
                        r_state       <= WAIT_GAP;
                        r_timer       <= 24'd0;
                        release_pulse <= 1'b1;
                    end else if (r_timer == LONG_CYCLES - 24'd1) begin
                        r_state    <= LONG;
                        r_timer    <= 24'd0;
                        long_press <= 1'b1;
                        held       <= 1'b1;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                LONG: begin
                    if (w_fall) begin
                        r_state       <= IDLE;
                        r_timer       <= 24'd0;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (r_timer == REPEAT_CYCLES - 24'd1) begin
                        r_timer      <= 24'd0;
                        repeat_pulse <= 1'b1;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                WAIT_GAP: begin
                    // A second press at the gap deadline still counts as double.
                    if (w_rise) begin
                        r_state      <= SECOND;
                        r_timer      <= 24'd0;
                        press_pulse  <= 1'b1;
                        double_click <= 1'b1;
                    end else if (r_timer == GAP_CYCLES - 24'd1) begin
                        r_state     <= IDLE;
                        r_timer     <= 24'd0;
                        short_press <= 1'b1;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                SECOND: begin
                    if (w_fall) begin
                        r_state       <= IDLE;
                        r_timer       <= 24'd0;
                        release_pulse <= 1'b1;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_timer <= 24'd0;
                    held    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_button_event_decoder.sv
// ============================================================================
// Module   : tb_button_event_decoder
// Purpose  : Directed and randomized checks of button_event_decoder against
//            a timestamp-based gesture model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_event_decoder;

    localparam int c_LONG   = 8;
    localparam int c_GAP    = 4;
    localparam int c_REPEAT = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic btn;
    logic press_pulse, release_pulse, short_press, double_click;
    logic long_press, repeat_pulse, held;

    int n_checks = 0;
    int n_errors = 0;

    // Gesture model: phase 0 idle, 1 first press, 2 release gap, 3 second press.
    int   m_phase;
    int   m_tevt;
    int   n_edge = 0;
    logic m_prev;
    logic e_press, e_release, e_short, e_double, e_long, e_repeat, e_held;

    button_event_decoder #(
        .LONG_CYCLES   (24'(c_LONG)),
        .GAP_CYCLES    (24'(c_GAP)),
        .REPEAT_CYCLES (24'(c_REPEAT))
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn           (btn),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_press   (short_press),
        .double_click  (double_click),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %b expected %b", tag, n_edge, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_tevt   = 0;
        m_prev   = 1'b0;
        e_press  = 1'b0; e_release = 1'b0; e_short = 1'b0; e_double = 1'b0;
        e_long   = 1'b0; e_repeat  = 1'b0; e_held  = 1'b0;
    endtask

    task automatic model_edge(input logic b);
        logic rise, fall;
        int   d;
        rise = b & ~m_prev;
        fall = ~b & m_prev;
        d    = n_edge - m_tevt;
        e_press = 1'b0; e_release = 1'b0; e_short = 1'b0; e_double = 1'b0;
        e_long  = 1'b0; e_repeat  = 1'b0;
        case (m_phase)
            0: if (rise) begin
                e_press = 1'b1; m_phase = 1; m_tevt = n_edge;
            end
            1: begin
                if (fall) begin
                    e_release = 1'b1;
                    if (d > c_LONG) begin
                        e_held = 1'b0; m_phase = 0;
                    end else begin
                        m_phase = 2; m_tevt = n_edge;
                    end
                end else if (d == c_LONG) begin
                    e_long = 1'b1; e_held = 1'b1;
                end else if (d > c_LONG && ((d - c_LONG) % c_REPEAT) == 0) begin
                    e_repeat = 1'b1;
                end
            end
            2: begin
                if (rise) begin
                    e_press = 1'b1; e_double = 1'b1; m_phase = 3;
                end else if (d == c_GAP) begin
                    e_short = 1'b1; m_phase = 0;
                end
            end
            default: if (fall) begin
                e_release = 1'b1; m_phase = 0;
            end
        endcase
        m_prev = b;
    endtask

    task automatic check_outputs();
        check_eq("press_pulse",   press_pulse,   e_press);
        check_eq("release_pulse", release_pulse, e_release);
        check_eq("short_press",   short_press,   e_short);
        check_eq("double_click",  double_click,  e_double);
        check_eq("long_press",    long_press,    e_long);
        check_eq("repeat_pulse",  repeat_pulse,  e_repeat);
        check_eq("held",          held,          e_held);
    endtask

    task automatic step(input logic b);
        btn = b;
        @(posedge clk);
        n_edge++;
        if (!rst_n) model_reset();
        else        model_edge(b);
        #1;
        check_outputs();
    endtask

    task automatic run(input logic b, input int cycles);
        for (int i = 0; i < cycles; i++) step(b);
    endtask

    // Assert reset away from any edge and prove outputs clear without a clock.
    task automatic pulse_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        for (int i = 0; i < cycles; i++) step(btn);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 1'b0;
        model_reset();
        #2;
        check_outputs();
        run(1'b0, 3);
        #2;
        rst_n = 1'b1;

        run(1'b1, 3);  run(1'b0, 10);                                // short
        run(1'b1, 3);  run(1'b0, 2);  run(1'b1, 3);  run(1'b0, 8);   // double
        run(1'b1, 20); run(1'b0, 8);                                 // long + repeat
        run(1'b1, 8);  run(1'b0, 10);                                // fall at long threshold
        run(1'b1, 8);  run(1'b1, 1);  run(1'b0, 4);                  // one past threshold
        run(1'b1, 2);  run(1'b0, 4);  run(1'b1, 2);  run(1'b0, 8);   // rise at gap expiry
        run(1'b1, 12); pulse_reset(3); run(1'b1, 4); run(1'b0, 10);  // reset in LONG
        btn = 1'b1;
        pulse_reset(2); run(1'b1, 2); run(1'b0, 10);                 // reset with btn high

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                pulse_reset($urandom_range(1, 3));
            end else if ($urandom_range(0, 3) == 0) begin
                run(~btn, $urandom_range(6, 22));
            end else begin
                run(~btn, $urandom_range(1, 6));
            end
        end
        run(1'b0, 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
